alu_cmd_master: RTL and testbench

ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_master_stats.sv | 29 ++
 rtl/alu_cmd_master.sv | 173 +++++++++++++++++
 tb/tb_alu_cmd_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, ALU command encodings, master FSM states and capture latencies
// for the ALU command master.
package alu_pkg;

  localparam int OPERAND_WIDTH_DEF = 8;
  localparam int CMD_WIDTH_DEF     = 4;

  // Arithmetic-mode command encodings understood by the attached ALU.
  typedef enum logic [3:0] {
    CMD_ADD     = 4'd0,
    CMD_SUB     = 4'd1,
    CMD_ADD_CIN = 4'd2,
    CMD_SUB_CIN = 4'd3,
    CMD_INC_A   = 4'd4,
    CMD_DEC_A   = 4'd5,
    CMD_INC_B   = 4'd6,
    CMD_DEC_B   = 4'd7,
    CMD_CMP     = 4'd8,
    CMD_MUL_INC = 4'd9,
    CMD_MUL_SHL = 4'd10
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } master_state_e;

  localparam logic [1:0] LAT_DEFAULT = 2'd2;
  localparam logic [1:0] LAT_MUL     = 2'd3;

  // Multiplies need one extra ALU cycle before RES is meaningful.
  function automatic logic [1:0] capture_latency(input logic mode, input logic [31:0] cmd);
    if (mode && ((cmd == 32'(CMD_MUL_INC)) || (cmd == 32'(CMD_MUL_SHL))))
      return LAT_MUL;
    return LAT_DEFAULT;
  endfunction

endpackage

// File: rtl/alu_master_stats.sv
// Saturating transaction and error counters, bumped on each response capture.
module alu_master_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_capture,
  input  logic        i_err,
  output logic [15:0] o_txn_count,
  output logic [15:0] o_err_count
);

  logic [15:0] r_txn_count;
  logic [15:0] r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txn_count <= '0;
      r_err_count <= '0;
    end else if (i_capture) begin
      if (r_txn_count != 16'hFFFF)
        r_txn_count <= r_txn_count + 16'd1;
      if (i_err && (r_err_count != 16'hFFFF))
        r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_txn_count = r_txn_count;
  assign o_err_count = r_err_count;

endmodule

// File: rtl/alu_cmd_master.sv
// Request/response front end that drives an external ALU one command at a time.
// Define ALU_MASTER_STATS_EN to add the txn_count/err_count statistics outputs.
module alu_cmd_master
  import alu_pkg::*;
#(
  parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF,
  parameter int CMD_WIDTH     = CMD_WIDTH_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_mode,
  input  logic [CMD_WIDTH-1:0]       req_cmd,
  input  logic [1:0]                 req_inp_valid,
  input  logic [OPERAND_WIDTH-1:0]   req_opa,
  input  logic [OPERAND_WIDTH-1:0]   req_opb,
  input  logic                       req_cin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2*OPERAND_WIDTH-1:0] rsp_res,
  output logic                       rsp_err,
  output logic                       rsp_oflow,
  output logic                       rsp_cout,
  output logic                       rsp_e,
  output logic                       rsp_g,
  output logic                       rsp_l,
  output logic                       CE,
  output logic                       MODE,
  output logic                       CIN,
  output logic [CMD_WIDTH-1:0]       CMD,
  output logic [1:0]                 INP_VALID,
  output logic [OPERAND_WIDTH-1:0]   OPA,
  output logic [OPERAND_WIDTH-1:0]   OPB,
  input  logic [2*OPERAND_WIDTH-1:0] RES,
  input  logic                       ERR,
  input  logic                       OFLOW,
  input  logic                       COUT,
  input  logic                       E,
  input  logic                       G,
  input  logic                       L
`ifdef ALU_MASTER_STATS_EN
  ,
  output logic [15:0]                txn_count,
  output logic [15:0]                err_count
`endif
);

  master_state_e              r_state;
  logic [1:0]                 r_cnt;
  logic                       r_req_ready;
  logic                       r_ce;
  logic                       r_mode;
  logic                       r_cin;
  logic [CMD_WIDTH-1:0]       r_cmd;
  logic [1:0]                 r_inp_valid;
  logic [OPERAND_WIDTH-1:0]   r_opa;
  logic [OPERAND_WIDTH-1:0]   r_opb;
  logic                       r_rsp_valid;
  logic [2*OPERAND_WIDTH-1:0] r_rsp_res;
  logic                       r_rsp_err;
  logic                       r_rsp_oflow;
  logic                       r_rsp_cout;
  logic                       r_rsp_e;
  logic                       r_rsp_g;
  logic                       r_rsp_l;

  logic [1:0] w_lat;
  logic       w_capture;

  // Latency follows the registered command, which is stable for all of DRIVE.
  assign w_lat     = capture_latency(r_mode, 32'(r_cmd));
  assign w_capture = (r_state == ST_DRIVE) && (r_cnt == w_lat);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_ce        <= 1'b0;
      r_mode      <= 1'b0;
      r_cin       <= 1'b0;
      r_cmd       <= '0;
      r_inp_valid <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_oflow <= 1'b0;
      r_rsp_cout  <= 1'b0;
      r_rsp_e     <= 1'b0;
      r_rsp_g     <= 1'b0;
      r_rsp_l     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_state     <= ST_DRIVE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_ce        <= 1'b1;
            r_mode      <= req_mode;
            r_cin       <= req_cin;
            r_cmd       <= req_cmd;
            r_inp_valid <= req_inp_valid;
            r_opa       <= req_opa;
            r_opb       <= req_opb;
          end
        end
        ST_DRIVE: begin
          if (w_capture) begin
            r_state     <= ST_RESP;
            r_ce        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_res   <= RES;
            r_rsp_err   <= ERR;
            r_rsp_oflow <= OFLOW;
            r_rsp_cout  <= COUT;
            r_rsp_e     <= E;
            r_rsp_g     <= G;
            r_rsp_l     <= L;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_RESP: begin
          // req_ready only returns on the following cycle: a one-cycle bubble.
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_ce        <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_res   = r_rsp_res;
  assign rsp_err   = r_rsp_err;
  assign rsp_oflow = r_rsp_oflow;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_e     = r_rsp_e;
  assign rsp_g     = r_rsp_g;
  assign rsp_l     = r_rsp_l;
  assign CE        = r_ce;
  assign MODE      = r_mode;
  assign CIN       = r_cin;
  assign CMD       = r_cmd;
  assign INP_VALID = r_inp_valid;
  assign OPA       = r_opa;
  assign OPB       = r_opb;

`ifdef ALU_MASTER_STATS_EN
  alu_master_stats u_stats (
    .clk         (CLK),
    .rst         (RST),
    .i_capture   (w_capture),
    .i_err       (ERR),
    .o_txn_count (txn_count),
    .o_err_count (err_count)
  );
`endif

endmodule

// File: tb/tb_alu_cmd_master.sv
// Bench for alu_cmd_master: a stand-in ALU, a cycle-level reference model of the
// master checked every cycle, and directed transactions with literal expectations.
module tb_alu_cmd_master;

  typedef struct packed {
    logic [15:0] res;
    logic        err;
    logic        oflow;
    logic        cout;
    logic        e;
    logic        g;
    logic        l;
  } alu_out_t;

  typedef struct packed {
    logic       mode;
    logic [3:0] cmd;
    logic [1:0] iv;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } drv_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_mode = 1'b0;
  logic [3:0]  req_cmd = '0;
  logic [1:0]  req_inp_valid = '0;
  logic [7:0]  req_opa = '0;
  logic [7:0]  req_opb = '0;
  logic        req_cin = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_res;
  logic        rsp_err, rsp_oflow, rsp_cout, rsp_e, rsp_g, rsp_l;
  logic        CE, MODE, CIN;
  logic [3:0]  CMD;
  logic [1:0]  INP_VALID;
  logic [7:0]  OPA, OPB;
  logic [15:0] RES;
  logic        ERR, OFLOW, COUT, E, G, L;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_cmd_master dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_cmd(req_cmd),
    .req_inp_valid(req_inp_valid), .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_err(rsp_err),
    .rsp_oflow(rsp_oflow), .rsp_cout(rsp_cout), .rsp_e(rsp_e), .rsp_g(rsp_g), .rsp_l(rsp_l),
    .CE(CE), .MODE(MODE), .CIN(CIN), .CMD(CMD), .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB),
    .RES(RES), .ERR(ERR), .OFLOW(OFLOW), .COUT(COUT), .E(E), .G(G), .L(L)
  );

  // Reference ALU behaviour (arithmetic mode=1, logic mode=0).
  function automatic alu_out_t alu_fn(input logic mode, input logic [3:0] cmd,
                                      input logic [1:0] iv, input logic [7:0] a,
                                      input logic [7:0] b, input logic cin);
    alu_out_t o;
    logic [15:0] a16, b16, c16;
    logic ok;
    o = '0;
    a16 = {8'h00, a};
    b16 = {8'h00, b};
    c16 = {15'd0, cin};
    if (mode) begin
      ok = (cmd == 4'd4 || cmd == 4'd5) ? iv[0] :
           (cmd == 4'd6 || cmd == 4'd7) ? iv[1] : (iv == 2'b11);
      if (!ok || cmd > 4'd10) o.err = 1'b1;
      else case (cmd)
        4'd0: begin o.res = a16 + b16; o.cout = o.res[8]; end
        4'd1: begin o.res = a16 - b16; o.oflow = (a < b); end
        4'd2: begin o.res = a16 + b16 + c16; o.cout = o.res[8]; end
        4'd3: begin o.res = a16 - b16 - c16; o.oflow = (a16 < b16 + c16); end
        4'd4: o.res = a16 + 16'd1;
        4'd5: o.res = a16 - 16'd1;
        4'd6: o.res = b16 + 16'd1;
        4'd7: o.res = b16 - 16'd1;
        4'd8: begin o.e = (a == b); o.g = (a > b); o.l = (a < b); end
        4'd9: o.res = (a16 + 16'd1) * (b16 + 16'd1);
        default: o.res = {8'h00, a[6:0], 1'b0} * b16;
      endcase
    end else begin
      ok = (cmd == 4'd6) ? iv[0] : (cmd == 4'd7) ? iv[1] : (iv == 2'b11);
      if (!ok || cmd > 4'd7) o.err = 1'b1;
      else case (cmd)
        4'd0: o.res = {8'h00, a & b};
        4'd1: o.res = {8'h00, ~(a & b)};
        4'd2: o.res = {8'h00, a | b};
        4'd3: o.res = {8'h00, ~(a | b)};
        4'd4: o.res = {8'h00, a ^ b};
        4'd5: o.res = {8'h00, ~(a ^ b)};
        4'd6: o.res = {8'h00, ~a};
        default: o.res = {8'h00, ~b};
      endcase
    end
    return o;
  endfunction

  function automatic int lat_fn(input logic mode, input logic [3:0] cmd);
    return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? 3 : 2;
  endfunction

  // Stand-in ALU: garbage outside CE so late or early capture is visible.
  alu_out_t w_alu;
  assign w_alu = alu_fn(MODE, CMD, INP_VALID, OPA, OPB, CIN);
  assign RES   = CE ? w_alu.res   : 16'hDEAD;
  assign ERR   = CE ? w_alu.err   : 1'b1;
  assign OFLOW = CE ? w_alu.oflow : 1'b1;
  assign COUT  = CE ? w_alu.cout  : 1'b1;
  assign E     = CE ? w_alu.e     : 1'b1;
  assign G     = CE ? w_alu.g     : 1'b1;
  assign L     = CE ? w_alu.l     : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: response is due L+1 edges after the accept edge.
  int       cyc = 0;
  int       m_rsp_at = 0;
  logic     m_busy = 1'b0;
  logic     m_rsp = 1'b0;
  drv_t     m_drv = '0;
  alu_out_t m_exp = '0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy <= 1'b0;
      m_rsp  <= 1'b0;
      m_drv  <= '0;
    end else begin
      cyc <= cyc + 1;
      if (!m_busy && req_valid) begin
        m_busy   <= 1'b1;
        m_rsp_at <= cyc + lat_fn(req_mode, req_cmd) + 1;
        m_drv    <= '{req_mode, req_cmd, req_inp_valid, req_opa, req_opb, req_cin};
        m_exp    <= alu_fn(req_mode, req_cmd, req_inp_valid, req_opa, req_opb, req_cin);
      end else if (m_busy && !m_rsp && cyc == m_rsp_at) begin
        m_rsp <= 1'b1;
      end else if (m_rsp && rsp_ready) begin
        m_busy <= 1'b0;
        m_rsp  <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    chk("req_ready", 32'(req_ready), 32'(!m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
    chk("ce", 32'(CE), 32'(m_busy && !m_rsp));
    chk("drive", 32'({MODE, CMD, INP_VALID, OPA, OPB, CIN}), 32'(m_drv));
    if (m_rsp)
      chk("rsp", 32'({rsp_res, rsp_err, rsp_oflow, rsp_cout, rsp_e, rsp_g, rsp_l}), 32'(m_exp));
  end

  task automatic do_txn(input logic mode, input logic [3:0] cmd, input logic [1:0] iv,
                        input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input int hold, output int n, output logic [15:0] res,
                        output logic [5:0] flg);
    req_mode = mode; req_cmd = cmd; req_inp_valid = iv;
    req_opa = a; req_opb = b; req_cin = cin; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout actual=no_response required=rsp_valid t=%0t", $time);
    end
    res = rsp_res;
    flg = {rsp_err, rsp_oflow, rsp_cout, rsp_e, rsp_g, rsp_l};
    repeat (hold) begin @(posedge CLK); #1; end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    $display("txn mode=%0d cmd=%0d iv=%b a=%h b=%h cin=%0d -> res=%h flags=%b edges=%0d",
             mode, cmd, iv, a, b, cin, res, flg, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] res;
    logic [5:0] flg;

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ce", 32'(CE), 32'd0);
    chk("rst_opa", 32'(OPA), 32'd0);
    chk("rst_rsp_res", 32'(rsp_res), 32'd0);
    @(posedge CLK); #1;

    do_txn(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0, 0, n, res, flg);
    chk("add_res", 32'(res), 32'h0100);
    chk("add_cout", 32'(flg[3]), 32'd1);
    chk("add_edges", 32'(n), 32'd3);

    do_txn(1'b1, 4'd9, 2'b11, 8'h03, 8'h04, 1'b0, 1, n, res, flg);
    chk("mulinc_res", 32'(res), 32'h0014);
    chk("mulinc_edges", 32'(n), 32'd4);

    do_txn(1'b1, 4'd10, 2'b11, 8'h03, 8'h04, 1'b0, 0, n, res, flg);
    chk("mulshl_res", 32'(res), 32'h0018);
    chk("mulshl_edges", 32'(n), 32'd4);

    do_txn(1'b1, 4'd1, 2'b11, 8'h02, 8'h05, 1'b0, 2, n, res, flg);
    chk("sub_res9", 32'(res[8:0]), 32'h1FD);
    chk("sub_oflow", 32'(flg[4]), 32'd1);

    do_txn(1'b1, 4'd8, 2'b11, 8'h55, 8'h55, 1'b0, 0, n, res, flg);
    chk("cmp_egl", 32'(flg[2:0]), 32'b100);

    do_txn(1'b0, 4'd0, 2'b01, 8'hF0, 8'h3C, 1'b0, 0, n, res, flg);
    chk("iv_err", 32'(flg[5]), 32'd1);
    chk("iv_res", 32'(res), 32'd0);

    do_txn(1'b0, 4'd4, 2'b11, 8'hA5, 8'h0F, 1'b0, 10, n, res, flg);
    chk("xor_res", 32'(res), 32'h00AA);
    chk("bubble_ready", 32'(req_ready), 32'd1);

    // Reset pulse while the ALU is being driven abandons the transaction.
    req_mode = 1'b1; req_cmd = 4'd2; req_inp_valid = 2'b11;
    req_opa = 8'h10; req_opb = 8'h20; req_cin = 1'b1; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    #2;
    chk("abort_ce", 32'(CE), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    $display("txn mode=1 cmd=2 abandoned by reset");
    repeat (6) begin
      @(posedge CLK); #1;
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end

    do_txn(1'b1, 4'd3, 2'b11, 8'h14, 8'h05, 1'b1, 0, n, res, flg);
    chk("subcin_res", 32'(res), 32'h000E);
    chk("subcin_edges", 32'(n), 32'd3);

    repeat (2) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
